// File: rtl/bcd_mod_counter_if.sv
// Bus bundle for one BCD modulo counter stage: count controls, preset
// request and the registered digits / carry / preset-error results.
//
// Protocol: there is no back-pressure. A stage advances on a rising CLK edge
// when ENABLE and CARRY_IN are both high and LOAD is low. LOAD is sampled on
// every rising edge and always wins over counting. CARRY_OUT is combinational
// so the next stage's CARRY_IN sees it before the same edge.
interface bcd_mod_counter_if;
  logic       ENABLE;
  logic       CARRY_IN;
  logic       DEC;
  logic       LOAD;
  logic [3:0] LOAD_TENS;
  logic [3:0] LOAD_ONES;
  logic [3:0] TENS;
  logic [3:0] ONES;
  logic       CARRY_OUT;
  logic       LOAD_ERR;

  modport master (
    output ENABLE, CARRY_IN, DEC, LOAD, LOAD_TENS, LOAD_ONES,
    input  TENS, ONES, CARRY_OUT, LOAD_ERR
  );

  modport slave (
    input  ENABLE, CARRY_IN, DEC, LOAD, LOAD_TENS, LOAD_ONES,
    output TENS, ONES, CARRY_OUT, LOAD_ERR
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down counter wrapping between MIN_VAL and MAX_VAL, with a
// validated synchronous preset and a combinational carry/borrow for chaining
// stages (e.g. seconds -> minutes -> hours).
module bcd_mod_counter #(
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 23
) (
  input  logic              CLK,
  input  logic              RESET,
  bcd_mod_counter_if.slave  bus
);

  localparam logic [3:0] MIN_TENS = 4'(MIN_VAL / 10);
  localparam logic [3:0] MIN_ONES = 4'(MIN_VAL % 10);
  localparam logic [3:0] MAX_TENS = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_VAL % 10);
  localparam logic [6:0] MIN_V7   = 7'(MIN_VAL);
  localparam logic [6:0] MAX_V7   = 7'(MAX_VAL);
  localparam logic [7:0] MIN_V8   = 8'(MIN_VAL);
  localparam logic [7:0] SPAN_V8  = 8'(MAX_VAL - MIN_VAL);

  logic [3:0] tens_q, ones_q;
  logic [3:0] tens_d, ones_d;
  logic       load_err_q, load_err_d;

  logic [6:0] value;
  logic       step;
  logic       at_min, at_max;
  logic [7:0] load_val;
  logic [7:0] load_off;
  logic       load_ok;

  assign value  = {3'b000, tens_q} * 7'd10 + {3'b000, ones_q};
  assign step   = bus.ENABLE & bus.CARRY_IN & ~bus.LOAD;
  assign at_min = (value == MIN_V7);
  assign at_max = (value == MAX_V7);

  // 8 bits hold the worst-case decode of two nibbles (15*10+15 = 165).
  assign load_val = {4'b0000, bus.LOAD_TENS} * 8'd10 + {4'b0000, bus.LOAD_ONES};
  // Unsigned offset from MIN_VAL: anything below MIN_VAL wraps to a large
  // number, so a single compare covers both ends of the range.
  assign load_off = load_val - MIN_V8;
  assign load_ok  = (bus.LOAD_TENS <= 4'd9) && (bus.LOAD_ONES <= 4'd9) &&
                    (load_off <= SPAN_V8);

  // Wrap carry/borrow: only on a real step, so it is low during LOAD.
  assign bus.CARRY_OUT = step & (bus.DEC ? at_min : at_max);
  assign bus.TENS      = tens_q;
  assign bus.ONES      = ones_q;
  assign bus.LOAD_ERR  = load_err_q;

  // Next digits and preset-error flag: LOAD first, then up/down step, else hold.
  always_comb begin
    tens_d     = tens_q;
    ones_d     = ones_q;
    load_err_d = 1'b0;
    if (bus.LOAD) begin
      if (load_ok) begin
        tens_d = bus.LOAD_TENS;
        ones_d = bus.LOAD_ONES;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (step) begin
      if (!bus.DEC) begin
        if (at_max) begin
          tens_d = MIN_TENS;
          ones_d = MIN_ONES;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (at_min) begin
          tens_d = MAX_TENS;
          ones_d = MAX_ONES;
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  // Digit and error registers; RESET forces MIN_VAL immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tens_q     <= MIN_TENS;
      ones_q     <= MIN_ONES;
      load_err_q <= 1'b0;
    end else begin
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      load_err_q <= load_err_d;
    end
  end

endmodule

// File: doc/bcd_mod_counter.md
BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 SHALL have parameter MIN_VAL, default 0, lowest count value (decimal).
REQ-002 SHALL have parameter MAX_VAL, default 23, highest count value (decimal); legal range 0 <= MIN_VAL < MAX_VAL <= 99.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ENABLE  input  1  count enable (tick).
REQ-006 SHALL have port CARRY_IN  input  1  chain carry/borrow from lower stage; tie high for the first stage.
REQ-007 SHALL have port DEC  input  1  direction: 0 = count up, 1 = count down.
REQ-008 SHALL have port LOAD  input  1  synchronous preset request.
REQ-009 SHALL have port LOAD_TENS  input  4  BCD tens digit to preset.
REQ-010 SHALL have port LOAD_ONES  input  4  BCD ones digit to preset.
REQ-011 SHALL have port TENS  output  4  registered BCD tens digit.
REQ-012 SHALL have port ONES  output  4  registered BCD ones digit.
REQ-013 SHALL have port CARRY_OUT  output  1  combinational wrap carry/borrow to the next stage.
REQ-014 SHALL have port LOAD_ERR  output  1  registered one-cycle pulse flagging a rejected preset.

Function
REQ-015 SHALL define VALUE = TENS*10 + ONES (7-bit); TENS and ONES SHALL each stay within 0..9 at all times.
REQ-016 SHALL define STEP = ENABLE & CARRY_IN & ~LOAD.
REQ-017 SHALL count up on a clock edge with STEP and DEC=0: if VALUE==MAX_VAL, load MIN_VAL digits; else if ONES==9, ONES->0 and TENS+1; else ONES+1.
REQ-018 SHALL count down on a clock edge with STEP and DEC=1: if VALUE==MIN_VAL, load MAX_VAL digits; else if ONES==0, ONES->9 and TENS-1; else ONES-1.
REQ-019 SHALL hold TENS/ONES when STEP=0 and LOAD=0.
REQ-020 SHALL drive CARRY_OUT = STEP & (DEC ? VALUE==MIN_VAL : VALUE==MAX_VAL), with no register delay, so that chained stages advance on the same edge.
REQ-021 SHALL give LOAD priority over counting; LOAD SHALL take effect regardless of ENABLE and CARRY_IN.
REQ-022 SHALL accept a preset only if LOAD_TENS<=9, LOAD_ONES<=9 and MIN_VAL <= LOAD_TENS*10+LOAD_ONES <= MAX_VAL; when accepted, it SHALL write both digits on that edge and leave LOAD_ERR at 0.
REQ-023 SHALL, on a rejected preset, hold TENS/ONES unchanged and set LOAD_ERR=1 for exactly the following cycle; LOAD held across multiple invalid edges SHALL keep LOAD_ERR high for each of them.
REQ-024 SHALL apply a DEC change on the next active edge; no extra step and no missed step SHALL occur.
REQ-025 SHALL produce CARRY_OUT=0 whenever LOAD=1.
REQ-026 SHALL reject a preset whose digits decode outside range (e.g. 0x2A); the counter SHALL never enter a non-BCD or out-of-range state through LOAD.

Reset
REQ-027 SHALL, while RESET=1, immediately force TENS/ONES to the MIN_VAL digits and LOAD_ERR=0, independent of CLK.
REQ-028 SHALL, on RESET release, resume normal operation from the first rising CLK edge; RESET asserted mid-count or mid-load SHALL discard that operation.

Verification
REQ-029 SHALL verify up-count wrap with default parameters: load 22, DEC=0, STEP for 2 edges -> 23 then 00; CARRY_OUT=1 only during the cycle with VALUE=23.
REQ-030 SHALL verify down-count borrow: reset (00), DEC=1, one STEP -> 23, CARRY_OUT=1 while at 00; next STEP from 20 -> 19.
REQ-031 SHALL verify MIN_VAL=1, MAX_VAL=12 (12-hour mode): reset -> 01; up from 12 -> 01; down from 01 -> 12; a load of 00 is rejected with LOAD_ERR pulse and the value is held.
REQ-032 SHALL verify presets: load 0x15 -> 15; load 0x24 or 0x1A -> value unchanged, LOAD_ERR=1 for one cycle; LOAD plus STEP on the same edge -> loaded value, CARRY_OUT=0.
REQ-033 SHALL verify chaining: two instances (MIN 0 / MAX 59 feeding MIN 0 / MAX 23) at 23:59, one STEP -> 00:00 on the same edge; the reverse direction from 00:00 -> 23:59.
REQ-034 SHALL verify asynchronous reset: assert RESET between clock edges at value 17 -> outputs go to MIN_VAL without waiting for CLK; LOAD_ERR=0.
